// File: rtl/uart_rx_model.sv
// Bench-side UART sink: deframes start/data/stop bits at a run-time bit period and reports each character.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchronizer on rxd (two cycles of extra latency).
module uart_rx_model (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ctrl_baud_clks,
  input  logic [3:0]  ctrl_bits,
  input  logic [1:0]  ctrl_stops,
  input  logic        rxd,
  output logic        rx_rdy,
  output logic        rx_err,
  output logic [31:0] rx_data
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic rxd_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];
`else
  assign rxd_s = rxd;
`endif

  // Zero-valued controls collapse to their minimum legal value.
  logic [15:0] n_eff;
  logic [3:0]  bits_eff;
  logic [1:0]  stops_eff;

  assign n_eff     = (ctrl_baud_clks == 16'd0) ? 16'd1 : ctrl_baud_clks;
  assign bits_eff  = (ctrl_bits == 4'd0)       ? 4'd1  : ctrl_bits;
  assign stops_eff = (ctrl_stops == 2'd0)      ? 2'd1  : ctrl_stops;

  state_t      state;
  logic        prev;
  logic [15:0] cnt;
  logic [15:0] n_lat;
  logic [15:0] half_lat;
  logic [3:0]  bits_lat;
  logic [1:0]  stops_lat;
  logic [3:0]  bit_idx;
  logic [1:0]  stop_idx;
  logic [14:0] shreg;

  logic        mid;
  logic        wrap;
  logic [15:0] cnt_adv;

  assign mid     = (cnt == half_lat);
  assign wrap    = (cnt == n_lat - 16'd1);
  assign cnt_adv = wrap ? 16'd0 : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 1'b1;
      cnt       <= '0;
      n_lat     <= 16'd1;
      half_lat  <= '0;
      bits_lat  <= 4'd1;
      stops_lat <= 2'd1;
      bit_idx   <= '0;
      stop_idx  <= '0;
      shreg     <= '0;
      rx_rdy    <= 1'b0;
      rx_err    <= 1'b0;
      rx_data   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values of cnt/state.
      rx_rdy <= 1'b0;
      rx_err <= 1'b0;
      unique case (state)
        IDLE: begin
          prev <= rxd_s;
          if (prev && !rxd_s) begin
            n_lat     <= n_eff;
            half_lat  <= n_eff >> 1;
            bits_lat  <= bits_eff;
            stops_lat <= stops_eff;
            bit_idx   <= '0;
            stop_idx  <= '0;
            shreg     <= '0;
            // The edge cycle is bit-cycle 0; with N=1 it is also the start-bit sample and wrap.
            if (n_eff == 16'd1) begin
              cnt   <= 16'd0;
              state <= DATA;
            end else begin
              cnt   <= 16'd1;
              state <= START;
            end
          end
        end

        START: begin
          cnt <= cnt_adv;
          if (mid && rxd_s) begin
            state <= IDLE;
            prev  <= 1'b1;
          end else if (wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          cnt <= cnt_adv;
          if (mid) shreg[bit_idx] <= rxd_s;
          if (wrap) begin
            if (bit_idx == bits_lat - 4'd1) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        STOP: begin
          cnt <= cnt_adv;
          if (mid && !rxd_s) begin
            rx_err  <= 1'b1;
            rx_data <= {17'd0, shreg};
            prev    <= 1'b0;
            state   <= IDLE;
          end else if (mid && stop_idx == stops_lat - 2'd1) begin
            // Leave from mid-stop so a back-to-back start edge is not missed.
            rx_rdy  <= 1'b1;
            rx_data <= {17'd0, shreg};
            prev    <= 1'b1;
            state   <= IDLE;
          end else if (wrap) begin
            stop_idx <= stop_idx + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_model.sv
// Directed bench for uart_rx_model: stimulus pushes expected strobes into a scoreboard,
// a negedge monitor pops and compares kind, data and arrival cycle.
module tb_uart_rx_model;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ctrl_baud_clks = 16'd2;
  logic [3:0]  ctrl_bits = 4'd8;
  logic [1:0]  ctrl_stops = 2'd1;
  logic        rxd = 1'b1;
  logic        rx_rdy;
  logic        rx_err;
  logic [31:0] rx_data;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  uart_rx_model dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_baud_clks (ctrl_baud_clks),
    .ctrl_bits      (ctrl_bits),
    .ctrl_stops     (ctrl_stops),
    .rxd            (rxd),
    .rx_rdy         (rx_rdy),
    .rx_err         (rx_err),
    .rx_data        (rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rx_rdy || rx_err)) begin
      check("rdy_err_exclusive", {31'd0, rx_rdy & rx_err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, rx_rdy, rx_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_is_err", {31'd0, rx_err}, {31'd0, e.err});
        check("rx_data", rx_data, e.data);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Called #1 after a posedge; that cycle becomes bit-cycle 0 of the frame.
  task automatic send(input logic [14:0] data, input logic stop_v, input logic [31:0] exp_data);
    int   n, nb, ns, s;
    exp_t e;
    n  = (ctrl_baud_clks == 0) ? 1 : int'(ctrl_baud_clks);
    nb = (ctrl_bits == 0) ? 1 : int'(ctrl_bits);
    ns = (ctrl_stops == 0) ? 1 : int'(ctrl_stops);
    s  = stop_v ? (nb + ns) * n + n / 2 : (nb + 1) * n + n / 2;
    e.err  = !stop_v;
    e.data = exp_data;
    e.cyc  = cyc + s + 1 + LAT;
    sb.push_back(e);
    drive_bit(1'b0, n);
    for (int k = 0; k < nb; k++) drive_bit(data[k], n);
    for (int j = 0; j < ns; j++) drive_bit(stop_v, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    check({tag, "_rx_rdy"}, {31'd0, rx_rdy}, 32'd0);
    check({tag, "_rx_err"}, {31'd0, rx_err}, 32'd0);
    check({tag, "_rx_data"}, rx_data, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // N=2, 8N1, 0x55: rx_rdy at cycle 20 after the start edge.
    ctrl_baud_clks = 16'd2; ctrl_bits = 4'd8; ctrl_stops = 2'd1;
    send(15'h55, 1'b1, 32'h0000_0055);
    idle(6);

    // N=4, 8N2, back-to-back 0xA3 then 0x0F.
    ctrl_baud_clks = 16'd4; ctrl_stops = 2'd2;
    send(15'hA3, 1'b1, 32'h0000_00A3);
    send(15'h0F, 1'b1, 32'h0000_000F);
    idle(8);

    // N=4 glitch: one low cycle is a false start.
    drive_bit(1'b0, 1);
    idle(20);
    @(negedge clk);
    check("false_start_data_held", rx_data, 32'h0000_000F);
    @(posedge clk);
    #1;
    send(15'h96, 1'b1, 32'h0000_0096);
    idle(6);

    // N=2, 8N1, 0xC4 with a zero stop bit; rxd stays low so no new frame may start.
    ctrl_baud_clks = 16'd2; ctrl_stops = 2'd1;
    send(15'hC4, 1'b0, 32'h0000_00C4);
    drive_bit(1'b0, 12);
    idle(6);
    send(15'h5A, 1'b1, 32'h0000_005A);
    idle(6);

    // Reset in the middle of data bit 3, then 0x3C after release.
    ctrl_baud_clks = 16'd4;
    drive_bit(1'b0, 4);
    drive_bit(1'b0, 4);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 4);
    drive_bit(1'b1, 2);
    rst_n = 1'b0;
    check_outputs_zero("midframe_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    send(15'h3C, 1'b1, 32'h0000_003C);
    idle(6);

    // Zero controls act as N=1, 1 data bit, 1 stop: rx_rdy at cycle 3.
    ctrl_baud_clks = 16'd0; ctrl_bits = 4'd0; ctrl_stops = 2'd0;
    send(15'h1, 1'b1, 32'h0000_0001);
    idle(4);
    // 3-bit frame at N=1 with two stops, value 0b101.
    ctrl_bits = 4'd3; ctrl_stops = 2'd2;
    send(15'h5, 1'b1, 32'h0000_0005);
    idle(4);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
